regbank_arbiter: RTL and testbench

REGBANK_ARBITER -- requirements
Module: regbank_arbiter

---
 rtl/regbank_arbiter.sv | 130 +++++++++++++
 tb/tb_regbank_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regbank_arbiter
//  Description : Two-requester arbiter serialising register-bank reads and
//                writes, one operation in flight, fixed 3-cycle cadence.
//  Revision    : 1.0  initial release
// ============================================================================
module regbank_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req0_we,
    input  logic [3:0]  req0_src1,
    input  logic [3:0]  req0_src2,
    input  logic [3:0]  req0_dst,
    input  logic [31:0] req0_wdata,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic        req1_we,
    input  logic [3:0]  req1_src1,
    input  logic [3:0]  req1_src2,
    input  logic [3:0]  req1_dst,
    input  logic [31:0] req1_wdata,
    output logic        req1_ready,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_a,
    output logic [31:0] rsp0_b,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_a,
    output logic [31:0] rsp1_b,
    output logic [3:0]  rb_src1,
    output logic [3:0]  rb_src2,
    output logic [3:0]  rb_dst,
    output logic [31:0] rb_z,
    output logic        rb_read_strobe,
    output logic        rb_write_strobe,
    input  logic [31:0] rb_a,
    input  logic [31:0] rb_b
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RD_ISSUE = 2'd1,
        S_WR_ISSUE = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_id;
    logic        r_we;
    logic        r_next_prio;
    logic [3:0]  r_src1;
    logic [3:0]  r_src2;
    logic [3:0]  r_dst;
    logic [31:0] r_wdata;

    logic        w_idle;
    logic        w_pick1;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_sel_we;
    logic        w_rd;
    logic        w_wr;
    logic        w_done;

    assign w_idle   = (r_state == S_IDLE);
    // r_next_prio names the requester that wins a tie; fixed mode pins it to 0.
    assign w_pick1  = req1_valid & (~req0_valid | ((FIXED_PRIO == 0) & r_next_prio));
    assign w_grant1 = w_idle & w_pick1;
    assign w_grant0 = w_idle & req0_valid & ~w_pick1;
    assign w_sel_we = w_grant1 ? req1_we : req0_we;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_id        <= 1'b0;
            r_we        <= 1'b0;
            r_next_prio <= 1'b0;
            r_src1      <= 4'd0;
            r_src2      <= 4'd0;
            r_dst       <= 4'd0;
            r_wdata     <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant0 | w_grant1) begin
                        r_id        <= w_grant1;
                        r_we        <= w_sel_we;
                        r_src1      <= w_grant1 ? req1_src1  : req0_src1;
                        r_src2      <= w_grant1 ? req1_src2  : req0_src2;
                        r_dst       <= w_grant1 ? req1_dst   : req0_dst;
                        r_wdata     <= w_grant1 ? req1_wdata : req0_wdata;
                        r_next_prio <= ~w_grant1;
                        r_state     <= w_sel_we ? S_WR_ISSUE : S_RD_ISSUE;
                    end
                end
                S_RD_ISSUE: r_state <= S_DONE;
                S_WR_ISSUE: r_state <= S_DONE;
                S_DONE:     r_state <= S_IDLE;
                default:    r_state <= S_IDLE;
            endcase
        end
    end

    assign w_rd   = (r_state == S_RD_ISSUE);
    assign w_wr   = (r_state == S_WR_ISSUE);
    assign w_done = (r_state == S_DONE);

    assign req0_ready      = w_grant0;
    assign req1_ready      = w_grant1;

    assign rb_read_strobe  = w_rd;
    assign rb_write_strobe = w_wr;
    assign rb_src1         = w_rd ? r_src1  : 4'd0;
    assign rb_src2         = w_rd ? r_src2  : 4'd0;
    assign rb_dst          = w_wr ? r_dst   : 4'd0;
    assign rb_z            = w_wr ? r_wdata : 32'd0;

    // The bank registers its read data on the strobe edge, so DONE passes it through.
    assign rsp0_valid = w_done & ~r_id;
    assign rsp1_valid = w_done &  r_id;
    assign rsp0_a     = (rsp0_valid & ~r_we) ? rb_a : 32'd0;
    assign rsp0_b     = (rsp0_valid & ~r_we) ? rb_b : 32'd0;
    assign rsp1_a     = (rsp1_valid & ~r_we) ? rb_a : 32'd0;
    assign rsp1_b     = (rsp1_valid & ~r_we) ? rb_b : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_regbank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regbank_arbiter
//  Description : Directed self-checking bench for regbank_arbiter with a
//                small register-bank model and a per-cycle protocol monitor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regbank_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req0_we = 1'b0;
    logic [3:0]  req0_src1 = 4'd0, req0_src2 = 4'd0, req0_dst = 4'd0;
    logic [31:0] req0_wdata = 32'd0;
    logic        req1_valid = 1'b0, req1_we = 1'b0;
    logic [3:0]  req1_src1 = 4'd0, req1_src2 = 4'd0, req1_dst = 4'd0;
    logic [31:0] req1_wdata = 32'd0;

    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_a, rsp0_b, rsp1_a, rsp1_b;
    logic [3:0]  rb_src1, rb_src2, rb_dst;
    logic [31:0] rb_z, rb_a, rb_b;
    logic        rb_read_strobe, rb_write_strobe;

    logic        f_req0_ready, f_req1_ready, f_rsp0_valid, f_rsp1_valid;
    logic [31:0] f_rsp0_a, f_rsp0_b, f_rsp1_a, f_rsp1_b;
    logic [3:0]  f_rb_src1, f_rb_src2, f_rb_dst;
    logic [31:0] f_rb_z;
    logic        f_rb_read_strobe, f_rb_write_strobe;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regbank_arbiter #(.FIXED_PRIO(0)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_src1(req0_src1),
        .req0_src2(req0_src2), .req0_dst(req0_dst), .req0_wdata(req0_wdata),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_src1(req1_src1),
        .req1_src2(req1_src2), .req1_dst(req1_dst), .req1_wdata(req1_wdata),
        .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_a(rsp0_a), .rsp0_b(rsp0_b),
        .rsp1_valid(rsp1_valid), .rsp1_a(rsp1_a), .rsp1_b(rsp1_b),
        .rb_src1(rb_src1), .rb_src2(rb_src2), .rb_dst(rb_dst), .rb_z(rb_z),
        .rb_read_strobe(rb_read_strobe), .rb_write_strobe(rb_write_strobe),
        .rb_a(rb_a), .rb_b(rb_b)
    );

    regbank_arbiter #(.FIXED_PRIO(1)) dut_fp (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_src1(req0_src1),
        .req0_src2(req0_src2), .req0_dst(req0_dst), .req0_wdata(req0_wdata),
        .req0_ready(f_req0_ready),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_src1(req1_src1),
        .req1_src2(req1_src2), .req1_dst(req1_dst), .req1_wdata(req1_wdata),
        .req1_ready(f_req1_ready),
        .rsp0_valid(f_rsp0_valid), .rsp0_a(f_rsp0_a), .rsp0_b(f_rsp0_b),
        .rsp1_valid(f_rsp1_valid), .rsp1_a(f_rsp1_a), .rsp1_b(f_rsp1_b),
        .rb_src1(f_rb_src1), .rb_src2(f_rb_src2), .rb_dst(f_rb_dst), .rb_z(f_rb_z),
        .rb_read_strobe(f_rb_read_strobe), .rb_write_strobe(f_rb_write_strobe),
        .rb_a(32'd0), .rb_b(32'd0)
    );

    // Register bank model: register 0 reads as zero, read data registered on strobe.
    logic [31:0] bank [16];
    initial begin
        for (int i = 0; i < 16; i++) bank[i] = 32'd0;
        rb_a = 32'd0;
        rb_b = 32'd0;
    end
    always @(posedge clk) begin
        if (rb_write_strobe && rb_dst != 4'd0) bank[rb_dst] <= rb_z;
        if (rb_read_strobe) begin
            rb_a <= bank[rb_src1];
            rb_b <= bank[rb_src2];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Protocol monitor: a response must follow a strobe cycle of the same instance.
    logic prev_strobe = 1'b0, f_prev_strobe = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            prev_strobe   = 1'b0;
            f_prev_strobe = 1'b0;
        end else begin
            chk("mon_both_strobes", {31'd0, rb_read_strobe & rb_write_strobe}, 32'd0);
            chk("mon_both_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
            chk("mon_rsp_outside_done", {31'd0, (rsp0_valid | rsp1_valid) & ~prev_strobe}, 32'd0);
            chk("mon_rsp0_data_idle", (rsp0_valid ? 32'd0 : (rsp0_a | rsp0_b)), 32'd0);
            chk("mon_rsp1_data_idle", (rsp1_valid ? 32'd0 : (rsp1_a | rsp1_b)), 32'd0);
            chk("mon_fp_both_strobes", {31'd0, f_rb_read_strobe & f_rb_write_strobe}, 32'd0);
            chk("mon_fp_both_ready", {31'd0, f_req0_ready & f_req1_ready}, 32'd0);
            chk("mon_fp_rsp_outside_done", {31'd0, (f_rsp0_valid | f_rsp1_valid) & ~f_prev_strobe}, 32'd0);
            prev_strobe   = rb_read_strobe | rb_write_strobe;
            f_prev_strobe = f_rb_read_strobe | f_rb_write_strobe;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int g0[6], t0[6], gf[6];
    int n0 = 0, nf = 0;
    logic fp_saw_ready1 = 1'b0;

    initial begin
        // Reset state
        #1;
        chk("rst_read_strobe", {31'd0, rb_read_strobe}, 32'd0);
        chk("rst_write_strobe", {31'd0, rb_write_strobe}, 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
        chk("rst_rsp_data", rsp0_a | rsp0_b | rsp1_a | rsp1_b, 32'd0);
        chk("rst_rb_addr", {20'd0, rb_src1, rb_src2, rb_dst}, 32'd0);
        chk("rst_rb_z", rb_z, 32'd0);
        step();
        step();
        reset = 1'b0;

        // req0 write dst=3
        req0_valid = 1'b1; req0_we = 1'b1; req0_dst = 4'd3; req0_wdata = 32'hDEADBEEF;
        #1;
        chk("wr_ready0", {31'd0, req0_ready}, 32'd1);
        chk("wr_ready1", {31'd0, req1_ready}, 32'd0);
        step();
        req0_valid = 1'b0; req0_dst = 4'd7; req0_wdata = 32'h0;
        chk("wr_strobe", {31'd0, rb_write_strobe}, 32'd1);
        chk("wr_dst", {28'd0, rb_dst}, 32'd3);
        chk("wr_z", rb_z, 32'hDEADBEEF);
        chk("wr_ready_busy", {31'd0, req0_ready}, 32'd0);
        step();
        chk("wr_strobe_off", {31'd0, rb_write_strobe}, 32'd0);
        chk("wr_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        chk("wr_rsp0_a", rsp0_a, 32'd0);
        chk("wr_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        step();
        chk("wr_rsp0_drop", {31'd0, rsp0_valid}, 32'd0);

        // req1 read src1=3 src2=0
        req1_valid = 1'b1; req1_we = 1'b0; req1_src1 = 4'd3; req1_src2 = 4'd0;
        #1;
        chk("rd_ready1", {31'd0, req1_ready}, 32'd1);
        step();
        req1_valid = 1'b0; req1_src1 = 4'd5; req1_src2 = 4'd9;
        chk("rd_strobe", {31'd0, rb_read_strobe}, 32'd1);
        chk("rd_src", {24'd0, rb_src1, rb_src2}, 32'h30);
        step();
        chk("rd_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
        chk("rd_rsp1_a", rsp1_a, 32'hDEADBEEF);
        chk("rd_rsp1_b", rsp1_b, 32'd0);
        chk("rd_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        step();

        // Write to register 0 is issued as usual
        req0_valid = 1'b1; req0_we = 1'b1; req0_dst = 4'd0; req0_wdata = 32'h12345678;
        step();
        req0_valid = 1'b0;
        chk("wr0_strobe", {31'd0, rb_write_strobe}, 32'd1);
        chk("wr0_z", rb_z, 32'h12345678);
        step();
        step();

        // Reset during RD_ISSUE
        req0_valid = 1'b1; req0_we = 1'b0; req0_src1 = 4'd3; req0_src2 = 4'd3;
        step();
        chk("rst_mid_strobe_pre", {31'd0, rb_read_strobe}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_strobe_drop", {31'd0, rb_read_strobe}, 32'd0);
        chk("rst_mid_rsp", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
        step();
        chk("rst_mid_rsp_later", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_rel_ready0", {31'd0, req0_ready}, 32'd1);
        chk("rst_rel_strobe", {31'd0, rb_read_strobe}, 32'd0);

        // Continuous contention on both instances
        req1_valid = 1'b1; req1_we = 1'b0; req1_src1 = 4'd3; req1_src2 = 4'd0;
        #1;
        for (int c = 0; c < 18; c++) begin
            if ((req0_ready | req1_ready) && n0 < 6) begin
                g0[n0] = req1_ready ? 1 : 0;
                t0[n0] = c;
                n0++;
            end
            if ((f_req0_ready | f_req1_ready) && nf < 6) begin
                gf[nf] = f_req1_ready ? 1 : 0;
                nf++;
            end
            if (f_req1_ready) fp_saw_ready1 = 1'b1;
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("rr_grant_count", n0, 6);
        chk("fp_grant_count", nf, 6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("rr_grant_%0d", k), g0[k], k % 2);
            chk($sformatf("fp_grant_%0d", k), gf[k], 0);
            if (k > 0) chk($sformatf("rr_spacing_%0d", k), t0[k] - t0[k-1], 3);
        end
        chk("fp_req1_never_ready", {31'd0, fp_saw_ready1}, 32'd0);
        step();
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
